// File: rtl/keccak_pkg.sv
// Shared constants, types and helpers for the Keccak-f[1600] slice pipeline.
// Slice bit i carries lane x = i % 5, y = i / 5.
package keccak_pkg;

  localparam int unsigned SLICE_W = 25;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned IDX_W   = $clog2(DEPTH);

  // Rho rotation amount for each lane, indexed by slice bit position.
  localparam int unsigned RHO_OFFS [SLICE_W] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } rho_state_e;

  function automatic int unsigned lane_x(input int unsigned i);
    return i % 5;
  endfunction

  function automatic int unsigned lane_y(input int unsigned i);
    return i / 5;
  endfunction

endpackage

// File: rtl/rho_bit_select.sv
// One output bit of the rho stage: picks bit (rz - OFFS) mod DEPTH out of
// one lane column, i.e. a left rotation of that lane by OFFS toward higher z.
module rho_bit_select
  import keccak_pkg::*;
#(
  parameter int unsigned OFFS = 0
) (
  input  logic [DEPTH-1:0] col_i,
  input  logic [IDX_W-1:0] rz_i,
  output logic             bit_o
);

  localparam logic [IDX_W-1:0] OFFS_W = IDX_W'(OFFS % DEPTH);

  logic [IDX_W-1:0] src_z;

  // Modular subtraction wraps naturally in IDX_W bits.
  assign src_z = rz_i - OFFS_W;
  assign bit_o = col_i[src_z];

endmodule

// File: rtl/rho_slice_buffer.sv
// Rho slice buffer: collects a full Keccak state slice by slice (FILL), then
// replays it with the rho lane rotations applied (DRAIN).
// Optional macro RHO_PARITY_CHECK_EN adds an XOR fold of input vs output
// slices with a sticky par_err flag; without it par_err is tied low.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in FILL and out_valid only in DRAIN, so the two
// channels never transfer in the same cycle. out_slice is held stable while
// out_valid && !out_ready. The FSM state is visible on busy (DRAIN).
module rho_slice_buffer
  import keccak_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SLICE_W-1:0] in_slice,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SLICE_W-1:0] out_slice,
  output logic               busy,
  output logic               par_err
);

  localparam logic [IDX_W-1:0] LAST_Z = IDX_W'(DEPTH - 1);

  rho_state_e       state_q, state_d;
  logic [IDX_W-1:0] wz_q, wz_d;
  logic [IDX_W-1:0] rz_q, rz_d;
  logic             in_hs;
  logic             out_hs;

  logic [SLICE_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]   cols  [SLICE_W];

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;
  assign busy   = (state_q == ST_DRAIN);

  // Next-state and handshake outputs of the FILL/DRAIN controller.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_FILL: begin
        in_ready = 1'b1;
        if (in_valid && (wz_q == LAST_Z)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && (rz_q == LAST_Z)) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Write/read index updates; each index is cleared when its phase begins.
  always_comb begin
    wz_d = wz_q;
    rz_d = rz_q;
    if (in_hs) begin
      wz_d = wz_q + 1'b1;
      if (wz_q == LAST_Z) rz_d = '0;
    end
    if (out_hs) begin
      rz_d = rz_q + 1'b1;
      if (rz_q == LAST_Z) wz_d = '0;
    end
  end

  // Controller state and indices; reset discards any partial state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FILL;
      wz_q    <= '0;
      rz_q    <= '0;
    end else begin
      state_q <= state_d;
      wz_q    <= wz_d;
      rz_q    <= rz_d;
    end
  end

  // Slice storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (in_hs) mem_q[wz_q] <= in_slice;
  end

  // Regroup storage into one 64-bit column per lane for the rotation muxes.
  always_comb begin
    for (int i = 0; i < SLICE_W; i++) begin
      cols[i] = '0;
      for (int z = 0; z < DEPTH; z++) begin
        cols[i][z] = mem_q[z][i];
      end
    end
  end

  for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_lane
    rho_bit_select #(
      .OFFS (RHO_OFFS[gi])
    ) u_sel (
      .col_i (cols[gi]),
      .rz_i  (rz_q),
      .bit_o (out_slice[gi])
    );
  end

`ifdef RHO_PARITY_CHECK_EN
  logic [SLICE_W-1:0] in_par_q,  in_par_d;
  logic [SLICE_W-1:0] out_par_q, out_par_d;
  logic               par_err_q, par_err_d;

  // Fold accepted and emitted slices; compare once the state is fully out.
  always_comb begin
    in_par_d  = in_par_q;
    out_par_d = out_par_q;
    par_err_d = par_err_q;
    if (in_hs) in_par_d = in_par_q ^ in_slice;
    if (out_hs) begin
      out_par_d = out_par_q ^ out_slice;
      if (rz_q == LAST_Z) begin
        if (in_par_q != (out_par_q ^ out_slice)) par_err_d = 1'b1;
        in_par_d  = '0;
        out_par_d = '0;
      end
    end
  end

  // Parity accumulators and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_par_q  <= '0;
      out_par_q <= '0;
      par_err_q <= 1'b0;
    end else begin
      in_par_q  <= in_par_d;
      out_par_q <= out_par_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_rho_slice_buffer.sv
module tb_rho_slice_buffer;
  import keccak_pkg::*;

  // Independent copy of the lane rotation amounts for the reference model.
  localparam int R_TB [25] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [SLICE_W-1:0] in_slice;
  logic               out_valid;
  logic               out_ready;
  logic [SLICE_W-1:0] out_slice;
  logic               busy;
  logic               par_err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [SLICE_W-1:0] exp_q[$];
  logic [SLICE_W-1:0] src [128];

  rho_slice_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_slice  (in_slice),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_slice (out_slice),
    .busy      (busy),
    .par_err   (par_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_slice  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- model ----------------
  function automatic void model_state(input int base);
    logic [SLICE_W-1:0] o;
    for (int z = 0; z < 64; z++) begin
      o = '0;
      for (int i = 0; i < 25; i++) begin
        o[i] = src[base + ((z - R_TB[i] + 64) % 64)][i];
      end
      exp_q.push_back(o);
    end
  endfunction

  function automatic void rand_src(input int base);
    logic [31:0] t;
    for (int z = 0; z < 64; z++) begin
      t = $urandom();
      src[base + z] = t[SLICE_W-1:0];
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic push_slice(input logic [SLICE_W-1:0] v);
    int c;
    in_valid = 1'b1;
    in_slice = v;
    c = 0;
    while (!in_ready && c < 300) begin
      @(negedge clk);
      c++;
    end
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL push_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, c);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic fill_src(input int base);
    for (int z = 0; z < 64; z++) push_slice(src[base + z]);
  endtask

  task automatic pop_check(input string name);
    int c;
    logic [SLICE_W-1:0] e;
    out_ready = 1'b1;
    c = 0;
    while (!out_valid && c < 300) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL %s_timeout: out_valid=%0b, required 1", name, out_valid);
    end else if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_extra: got %h, required no slice", name, out_slice);
    end else begin
      e = exp_q.pop_front();
      if (out_slice !== e) begin
        n_fail++;
        $display("FAIL %s: out_slice=%h required %h", name, out_slice, e);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic drain_n(input string name, input int n);
    for (int k = 0; k < n; k++) pop_check(name);
  endtask

  task automatic check_idle(input string name);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: in_ready=%0b out_valid=%0b busy=%0b required 1/0/0",
               name, in_ready, out_valid, busy);
    end
  endtask

  task automatic check_par0(input string name);
    n_cmp++;
    if (par_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: par_err=%0b required 0", name, par_err);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    check_idle("reset_idle");
    check_par0("reset_par_err");
  endtask

  task automatic test_impulse();
    for (int z = 0; z < 64; z++) src[z] = '0;
    src[0] = 25'h0000002;
    for (int z = 0; z < 64; z++) exp_q.push_back((z == 1) ? 25'h0000002 : 25'h0);
    fill_src(0);
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_to_drain: out_valid=%0b in_ready=%0b busy=%0b required 1/0/1",
               out_valid, in_ready, busy);
    end
    drain_n("impulse", 64);
    check_idle("drain_to_fill");
  endtask

  task automatic test_wrap();
    for (int z = 0; z < 64; z++) src[z] = '0;
    src[3]  = 25'h0000004;
    src[63] = 25'h0000001;
    for (int z = 0; z < 64; z++)
      exp_q.push_back((z == 1) ? 25'h0000004 : (z == 63) ? 25'h0000001 : 25'h0);
    fill_src(0);
    drain_n("wrap", 64);
  endtask

  task automatic test_back_to_back();
    int ni, no, cyc;
    logic [SLICE_W-1:0] e;
    rand_src(0);
    rand_src(64);
    model_state(0);
    model_state(64);
    ni = 0; no = 0; cyc = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (no < 128 && cyc < 600) begin
      if (ni < 128) begin
        in_slice = src[ni];
        if (in_ready) ni++;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (out_slice !== e) begin
          n_fail++;
          $display("FAIL b2b_slice%0d: out_slice=%h required %h", no, out_slice, e);
        end
        no++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (cyc != 256 || no != 128) begin
      n_fail++;
      $display("FAIL b2b_cycles: %0d cycles for %0d slices, required 256 for 128", cyc, no);
    end
  endtask

  task automatic test_backpressure();
    logic [SLICE_W-1:0] held;
    rand_src(0);
    model_state(0);
    fill_src(0);
    drain_n("bp_pre", 7);
    held = exp_q[0];
    // Junk on the input side must be ignored while draining.
    in_valid = 1'b1;
    in_slice = 25'h1ABCDEF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_slice !== held) begin
        n_fail++;
        $display("FAIL bp_hold%0d: out_valid=%0b out_slice=%h required 1 %h",
                 k, out_valid, out_slice, held);
      end
    end
    in_valid = 1'b0;
    drain_n("bp_post", 57);
    check_idle("bp_done");
  endtask

  task automatic test_reset_mid_drain();
    rand_src(0);
    model_state(0);
    fill_src(0);
    drain_n("rst_pre", 30);
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_mid_drain");
    check_par0("rst_mid_par");
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_release");
    exp_q.delete();
    rand_src(0);
    model_state(0);
    fill_src(0);
    drain_n("rst_fresh", 64);
    check_par0("clean_par_err");
  endtask

`ifdef RHO_PARITY_CHECK_EN
  task automatic test_parity();
    rand_src(0);
    fill_src(0);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    dut.mem_q[50] = dut.mem_q[50] ^ 25'h0000008;
    repeat (59) @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (par_err !== 1'b1) begin
      n_fail++;
      $display("FAIL par_err_set: par_err=%0b required 1", par_err);
    end
    rand_src(0);
    model_state(0);
    fill_src(0);
    drain_n("par_clean", 64);
    n_cmp++;
    if (par_err !== 1'b1) begin
      n_fail++;
      $display("FAIL par_err_sticky: par_err=%0b required 1", par_err);
    end
    do_reset();
    check_par0("par_err_cleared");
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_impulse();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_drain();
`ifdef RHO_PARITY_CHECK_EN
    test_parity();
`endif
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d slices pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rho_slice_buffer.md
# rho_slice_buffer

Downstream neighbour of the column-parity (theta) datapath in the Keccak-f[1600] slice pipeline. It accepts the 64 theta-output slices of one state, 25 bits each, over a valid/ready handshake and stores them. It then replays 64 slices with the rho lane rotations applied, for the next (pi) stage. A full state must be buffered before output can start, because rho moves bits between slices.

## Interface
- `SLICE_W`, 25: bits per slice. Bit i is lane x = i % 5, y = i / 5, the same mapping the theta stage uses.
- `DEPTH`, 64: slices per state, which is also the lane length. Must be a power of two.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream slice valid.
- `in_ready`  out  1  block accepts a slice this cycle.
- `in_slice`  in  SLICE_W  theta-output slice; slice z arrives z-th, starting at z = 0.
- `out_valid`  out  1  `out_slice` valid.
- `out_ready`  in  1  downstream accepts.
- `out_slice`  out  SLICE_W  rho-output slice, emitted in order z = 0..63.
- `busy`  out  1  high while in DRAIN.
- `par_err`  out  1  parity-check sticky error. Present only with the macro; see Configuration.

## Operation
- Storage: DEPTH × SLICE_W flop array `mem`. Write index `wz` and read index `rz` are 6-bit counters that wrap mod 64.
- States:
  - FILL (reset state): `in_ready`=1, `out_valid`=0. Each handshake (`in_valid && in_ready`) writes `mem[wz]` and increments `wz`. The handshake at `wz`=63 moves the FSM to DRAIN and clears `rz`.
  - DRAIN: `in_ready`=0, `out_valid`=1. Each handshake (`out_valid && out_ready`) increments `rz`. The handshake at `rz`=63 returns the FSM to FILL and clears `wz`.
- Rho: `out_slice[i]` = `mem[(rz - r[i]) mod 64][i]`. This is a left rotation of lane i by r[i] toward higher z. The subtraction is 6-bit and wraps naturally.
- Offsets r[i] for i = 0..24: 0,1,62,28,27, 36,44,6,55,20, 3,10,43,25,39, 41,45,15,21,8, 18,2,61,56,14.
- `out_slice` is a combinational function of `mem` and `rz`. It stays stable while `out_valid && !out_ready`.
- `in_slice` is ignored whenever `in_ready`=0.
- Handshakes can never overlap, because `in_ready` and `out_valid` are never high in the same cycle.
- Reset (any time, including mid-FILL or mid-DRAIN):
  - state returns to FILL and `wz` = `rz` = 0;
  - `in_ready`=1 and `out_valid`=0 from the first edge after release;
  - `busy`=0 and `par_err`=0;
  - `mem` is not cleared; a partially received state is discarded.

## Timing
- `in_ready` rises in the cycle after the last DRAIN handshake.
- `out_valid` rises in the cycle after the 64th input handshake.
- Latency from the 64th input accepted to the first output slice: 1 cycle.
- Throughput: 1 slice/cycle in each phase, so 128 cycles per state with no stalls.
- `in_valid` may drop at any time; FILL simply waits.
- `out_ready` low stalls DRAIN indefinitely with no data loss.

## Configuration
- `RHO_PARITY_CHECK_EN`
  - Defined: XOR accumulators fold every accepted input slice and every emitted output slice. Both clear at the start of each state. At the final DRAIN handshake the two are compared; a mismatch sets `par_err` (sticky until reset). Rho is a bit permutation, so the XOR reductions must match.
  - Undefined: `par_err` is tied 0 and no accumulator logic exists.

## Structure
- Shared package `keccak_pkg`: `SLICE_W`, `DEPTH`, the 25-entry `RHO_OFFS` constant array, the FILL/DRAIN state enum, and the `lane_x(i)`/`lane_y(i)` helpers.
- One sub-module, `rho_bit_select`: a per-bit 64:1 mux that takes `mem` column i, `rz` and the constant r[i]. It is instantiated 25 times.

## Test plan
- Impulse, lane 1: slice 0 = 25'h0000002, all other slices 0 → output slice 1 = 25'h0000002; all other outputs 0.
- Wrap: slice 3 = 25'h0000004 (lane 2, r=62) → output slice 1 = 25'h0000004. Slice 63 bit 0 → output slice 63 bit 0.
- Random 64-slice state compared against a software rho model. Run two states back-to-back with `in_valid`/`out_ready` held high → 128 cycles per state, no bubbles.
- Backpressure: `out_ready` = 0 for 10 cycles at `rz`=7 → `out_slice` is held constant, and slice 7 is emitted once.
- Reset asserted mid-DRAIN at `rz`=30 → next cycle `out_valid`=0 and `in_ready`=1. A fresh state then produces correct output.
- `RHO_PARITY_CHECK_EN` defined: force a bit flip in `mem` during DRAIN → `par_err`=1 after slice 63 and stays 1 until reset. With clean data `par_err` stays 0.
